// File: rtl/button_conditioner.sv
// Per-channel input conditioner: 2-FF sync, tick-gated debounce, edge pulse, auto-repeat, sticky flag.
// Latency: level/pulse follow s by 2 clk + DB_CYCLES en ticks; evt one clk after pulse; no backpressure.
module button_conditioner #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 16,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] s,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] evt
);

    localparam int DBW    = $clog2(DB_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW    = $clog2(RP_MAX + 1);
    localparam bit REP_EN = (REPEAT_DELAY > 0) && (EDGE_MODE != 1);
    localparam int RD_M1  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int RP_M1  = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;

    typedef enum logic [1:0] {
        RP_IDLE,
        RP_WAIT,
        RP_REPEAT
    } rp_state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic           sync1;
        logic           sync0;
        logic           lvl_q;
        logic           lvl_nxt;
        logic           pls_q;
        logic           evt_q;
        logic [DBW-1:0] db_cnt;
        logic [DBW-1:0] db_cnt_nxt;
        logic           accept;
        logic           acc_rise;
        logic           acc_fall;
        logic           edge_hit;
        logic           rep_fire;
        rp_state_t      rp_state;
        rp_state_t      rp_state_nxt;
        logic [RPW-1:0] rp_cnt;
        logic [RPW-1:0] rp_cnt_nxt;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1  <= 1'b0;
                sync0  <= 1'b0;
                lvl_q  <= 1'b0;
                pls_q  <= 1'b0;
                evt_q  <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1  <= s[i];
                sync0  <= sync1;
                lvl_q  <= lvl_nxt;
                db_cnt <= db_cnt_nxt;
                pls_q  <= edge_hit | rep_fire;
                // Set wins over clear so an event arriving during clr is not lost.
                if (pls_q) begin
                    evt_q <= 1'b1;
                end else if (clr[i]) begin
                    evt_q <= 1'b0;
                end
            end
        end

        always_comb begin
            db_cnt_nxt = db_cnt;
            lvl_nxt    = lvl_q;
            accept     = 1'b0;
            if (en) begin
                if (sync0 == lvl_q) begin
                    db_cnt_nxt = '0;
                end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
                    lvl_nxt    = sync0;
                    db_cnt_nxt = '0;
                    accept     = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            acc_rise = accept & sync0;
            acc_fall = accept & ~sync0;
            case (EDGE_MODE)
                0:       edge_hit = acc_rise;
                1:       edge_hit = acc_fall;
                default: edge_hit = accept;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rp_state <= RP_IDLE;
                rp_cnt   <= '0;
            end else begin
                rp_state <= rp_state_nxt;
                rp_cnt   <= rp_cnt_nxt;
            end
        end

        always_comb begin
            rp_state_nxt = rp_state;
            rp_cnt_nxt   = rp_cnt;
            rep_fire     = 1'b0;
            if (!REP_EN) begin
                rp_state_nxt = RP_IDLE;
                rp_cnt_nxt   = '0;
            end else begin
                case (rp_state)
                    RP_IDLE: begin
                        rp_cnt_nxt = '0;
                        if (acc_rise) begin
                            rp_state_nxt = RP_WAIT;
                        end
                    end
                    RP_WAIT, RP_REPEAT: begin
                        // A release being accepted this tick cancels any repeat due now.
                        if (!lvl_q || acc_fall) begin
                            rp_state_nxt = RP_IDLE;
                            rp_cnt_nxt   = '0;
                        end else if (en) begin
                            if (rp_cnt == RPW'((rp_state == RP_WAIT) ? RD_M1 : RP_M1)) begin
                                rep_fire     = 1'b1;
                                rp_state_nxt = RP_REPEAT;
                                rp_cnt_nxt   = '0;
                            end else begin
                                rp_cnt_nxt = rp_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        rp_state_nxt = RP_IDLE;
                        rp_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign level[i] = lvl_q;
        assign pulse[i] = pls_q;
        assign evt[i]   = evt_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: four parameter sets share one stimulus stream and are
// checked every cycle against a history/tick-count model, plus directed literal checks.
module tb_button_conditioner;

    localparam int NI = 4;
    localparam int DB   [NI] = '{4, 4, 4, 1};
    localparam int MODE [NI] = '{0, 2, 1, 0};
    localparam int RD   [NI] = '{0, 0, 0, 3};
    localparam int RP   [NI] = '{8, 8, 8, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] s;
    logic [3:0] clr;
    logic [3:0] d_lvl [NI];
    logic [3:0] d_pls [NI];
    logic [3:0] d_evt [NI];

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    button_conditioner #(.N_CH(4), .DB_CYCLES(4), .EDGE_MODE(0), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .clr(clr),
        .level(d_lvl[0]), .pulse(d_pls[0]), .evt(d_evt[0]));
    button_conditioner #(.N_CH(4), .DB_CYCLES(4), .EDGE_MODE(2), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .clr(clr),
        .level(d_lvl[1]), .pulse(d_pls[1]), .evt(d_evt[1]));
    button_conditioner #(.N_CH(4), .DB_CYCLES(4), .EDGE_MODE(1), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .clr(clr),
        .level(d_lvl[2]), .pulse(d_pls[2]), .evt(d_evt[2]));
    button_conditioner #(.N_CH(4), .DB_CYCLES(1), .EDGE_MODE(0), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)) ur (
        .clk(clk), .rst(rst), .en(en), .s(s), .clr(clr),
        .level(d_lvl[3]), .pulse(d_pls[3]), .evt(d_evt[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a level is accepted once the last DB en-tick samples of the synchronised input
    // all disagree with it; repeats fire DELAY, DELAY+PERIOD, ... en ticks after a rise.
    bit          m_s1   [NI][4];
    bit          m_s0   [NI][4];
    bit          m_lvl  [NI][4];
    bit          m_pls  [NI][4];
    bit          m_evt  [NI][4];
    logic [15:0] m_hist [NI][4];
    int          m_ns   [NI][4];
    bit          m_ract [NI][4];
    int          m_t    [NI][4];

    logic [15:0] h, mask;
    int          ns, t;
    bit          lv, acc_r, acc_f, np, ra;

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (rst) begin
                    m_s1[k][c] <= 1'b0; m_s0[k][c] <= 1'b0; m_lvl[k][c] <= 1'b0;
                    m_pls[k][c] <= 1'b0; m_evt[k][c] <= 1'b0; m_hist[k][c] <= '0;
                    m_ns[k][c] <= 0; m_ract[k][c] <= 1'b0; m_t[k][c] <= 0;
                end else begin
                    h = m_hist[k][c]; ns = m_ns[k][c]; lv = m_lvl[k][c];
                    t = m_t[k][c]; ra = m_ract[k][c];
                    acc_r = 1'b0; acc_f = 1'b0; np = 1'b0;
                    if (en) begin
                        h = {h[14:0], m_s0[k][c]};
                        if (ns < 16) ns++;
                        mask = (16'(1) << DB[k]) - 16'd1;
                        if (ns >= DB[k] && (h & mask) == (lv ? 16'd0 : mask)) begin
                            if (lv) acc_f = 1'b1;
                            else    acc_r = 1'b1;
                        end
                        if (RD[k] > 0 && MODE[k] != 1 && ra && lv && !acc_f) begin
                            t++;
                            if (t == RD[k] || (t > RD[k] && (t - RD[k]) % RP[k] == 0)) np = 1'b1;
                        end
                        if (acc_r) begin ra = 1'b1; t = 0; if (MODE[k] != 1) np = 1'b1; end
                        if (acc_f) begin ra = 1'b0; t = 0; if (MODE[k] != 0) np = 1'b1; end
                    end
                    m_hist[k][c] <= h; m_ns[k][c] <= ns; m_t[k][c] <= t; m_ract[k][c] <= ra;
                    m_lvl[k][c]  <= lv ^ (acc_r | acc_f);
                    m_pls[k][c]  <= np;
                    m_evt[k][c]  <= m_pls[k][c] ? 1'b1 : (clr[c] ? 1'b0 : m_evt[k][c]);
                    m_s0[k][c]   <= m_s1[k][c];
                    m_s1[k][c]   <= s[c];
                end
            end
        end
    end

    logic [3:0] mv_l, mv_p, mv_e;
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < 4; c++) begin
                    mv_l[c] = m_lvl[k][c]; mv_p[c] = m_pls[k][c]; mv_e[c] = m_evt[k][c];
                end
                check($sformatf("model inst%0d level", k), 32'(d_lvl[k]), 32'(mv_l));
                check($sformatf("model inst%0d pulse", k), 32'(d_pls[k]), 32'(mv_p));
                check($sformatf("model inst%0d evt", k),   32'(d_evt[k]), 32'(mv_e));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int first, first_r, cnt, cnt2, rcnt, late, found;
    int rtimes [4];
    bit ored;

    initial begin
        rst = 1'b1; en = 1'b1; s = '0; clr = '0;
        @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset level", 32'(d_lvl[0]), 32'h0);
        check("reset pulse", 32'(d_pls[3]), 32'h0);
        check("reset evt",   32'(d_evt[1]), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Rise on s[0]: DB=4 pulse 6 clk later once; DB=1 repeat instance at 3,6,8,10,12.
        s[0] = 1'b1; first = -1; cnt = 0; rcnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (d_pls[0][0]) begin cnt++; if (first < 0) first = i; end
            if (d_pls[3][0]) begin if (rcnt < 4) rtimes[rcnt] = i; rcnt++; end
        end
        check("t1 first pulse cycle", first, 6);
        check("t1 pulse count", cnt, 1);
        check("t1 level", 32'(d_lvl[0][0]), 1);
        check("t1 evt", 32'(d_evt[0][0]), 1);
        check("t5 repeat count", rcnt, 5);
        check("t5 pulse 0", rtimes[0], 3);
        check("t5 pulse 1", rtimes[1], 6);
        check("t5 pulse 2", rtimes[2], 8);
        check("t5 pulse 3", rtimes[3], 10);

        s[0] = 1'b0; late = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i >= 4 && d_pls[3][0]) late++;
        end
        check("t5 repeats after release", late, 0);
        check("t5 level released", 32'(d_lvl[3][0]), 0);
        check("t1 level released", 32'(d_lvl[0][0]), 0);

        clr = '1;
        @(negedge clk);
        clr = '0;
        check("clr all evt", 32'(d_evt[0]), 0);

        // Glitch of 3 clk on s[1] never reaches DB=4 acceptance.
        ored = 1'b0;
        s[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) s[1] = 1'b0;
            @(negedge clk);
            ored = ored | d_lvl[0][1] | d_pls[0][1] | d_evt[0][1];
        end
        check("t2 glitch rejected", 32'(ored), 0);

        // en one tick in four: accept after 4 ticks, pulse one clk wide.
        first = -1; cnt = 0;
        for (int i = 0; i < 24; i++) begin
            en = (i % 4 == 0);
            if (i == 0) s[2] = 1'b1;
            @(negedge clk);
            if (d_pls[0][2]) begin cnt++; if (first < 0) first = i + 1; end
        end
        en = 1'b1;
        check("t3 first pulse cycle", first, 17);
        check("t3 pulse count", cnt, 1);
        check("t3 level", 32'(d_lvl[0][2]), 1);

        // Press/release on s[3]: both-edge instance twice, fall instance once on release.
        cnt = 0; cnt2 = 0; found = 0;
        s[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_pls[1][3]) cnt++;
            if (d_pls[2][3]) cnt2++;
        end
        s[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d_pls[1][3]) cnt++;
            if (d_pls[2][3]) found++;
        end
        check("t4 both-edge pulses", cnt, 2);
        check("t4 fall-mode press pulses", cnt2, 0);
        check("t4 fall-mode release pulses", found, 1);

        // Clear coinciding with pulse: set wins, clear next cycle takes effect.
        clr = '1;
        @(negedge clk);
        clr = '0;
        s[0] = 1'b1; found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d_pls[0][0]) begin found = 1; break; end
        end
        check("t6 pulse seen", found, 1);
        clr[0] = 1'b1;
        @(negedge clk);
        check("t6 set wins over clr", 32'(d_evt[0][0]), 1);
        @(negedge clk);
        check("t6 clr clears", 32'(d_evt[0][0]), 0);
        clr[0] = 1'b0;

        // Reset while the repeat instance waits for its first repeat.
        s[0] = 1'b0;
        repeat (12) @(negedge clk);
        s[0] = 1'b1; found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_pls[3][0]) begin found = 1; break; end
        end
        check("t6 repeat accept seen", found, 1);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("t6 rst inst%0d outputs", k),
                  32'({d_lvl[k], d_pls[k], d_evt[k]}), 0);
        end
        rst = 1'b0;
        first = -1; first_r = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (d_pls[0][0] && first < 0) first = i;
            if (d_pls[3][0] && first_r < 0) first_r = i;
        end
        check("t6 full debounce after rst", first, 6);
        check("t6 repeat inst after rst", first_r, 3);

        s = '0;
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
